display_bram_scheduler: RTL and testbench

- Write-side controller for the 32 KiB display tile BRAM that the display tiler reads.
- Arbitrates pixel writes from up to NREQ CNN producers (input image, conv1, conv2, probability head) onto the single BRAM write port.
- Translates (tile, offset) into a byte address using the fixed tile layout.
- Double-buffers the BRAM in two banks and swaps banks only on a display start-of-frame, once every producer has finished its frame, so the display never tears.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/display_bram_scheduler.sv | 109 ++++++++++
 tb/tb_display_bram_scheduler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and tile layout for the display BRAM write path.
// tile_base() maps a tile index onto its byte base, size and validity.
package display_pkg;

  localparam int NUM_TILES = 22;

  localparam logic [13:0] T0_BASE   = 14'h0000;
  localparam logic [10:0] T0_SIZE   = 11'd784;
  localparam logic [13:0] TM_BASE   = 14'h0320;
  localparam logic [13:0] TM_STRIDE = 14'h0240;
  localparam logic [10:0] TM_SIZE   = 11'd576;
  localparam logic [13:0] TS_BASE   = 14'h2720;
  localparam logic [13:0] TS_STRIDE = 14'h0040;
  localparam logic [10:0] TS_SIZE   = 11'd64;
  localparam logic [13:0] TL_BASE   = 14'h2820;
  localparam logic [10:0] TL_SIZE   = 11'd10;

  typedef enum logic [1:0] {FILL, ARMED, SWAP} sched_state_t;

  typedef struct packed {
    logic [13:0] base;
    logic [10:0] size;
    logic        valid;
  } tile_info_t;

  function automatic tile_info_t tile_base(input logic [7:0] tile);
    tile_info_t  ti;
    logic [13:0] t14;
    t14 = {6'd0, tile};
    ti  = '0;
    if (tile == 8'd0) begin
      ti.base = T0_BASE; ti.size = T0_SIZE; ti.valid = 1'b1;
    end else if (tile <= 8'd16) begin
      ti.base = TM_BASE + (t14 - 14'd1) * TM_STRIDE; ti.size = TM_SIZE; ti.valid = 1'b1;
    end else if (tile <= 8'd20) begin
      ti.base = TS_BASE + (t14 - 14'd17) * TS_STRIDE; ti.size = TS_SIZE; ti.valid = 1'b1;
    end else if (tile == 8'(NUM_TILES - 1)) begin
      ti.base = TL_BASE; ti.size = TL_SIZE; ti.valid = 1'b1;
    end
    return ti;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
// The pointer moves past the winner on every grant and holds otherwise.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [IW-1:0] ptr;
  logic          found;
  int            idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (found)
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
  end

endmodule

// File: rtl/display_bram_scheduler.sv
// Write-side scheduler for the double-buffered display tile BRAM: arbitrates
// producer writes into the hidden bank and swaps banks on sof once all are done.
module display_bram_scheduler
  import display_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TILE_BITS = 5,
  parameter int OFFS_BITS = 10,
  parameter int BANK_BIT  = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*TILE_BITS-1:0] req_tile,
  input  logic [NREQ*OFFS_BITS-1:0] req_offs,
  input  logic [NREQ*8-1:0]         req_data,
  input  logic [NREQ-1:0]           req_last,
  input  logic                      sof,
  output logic                      wr_en,
  output logic [15:0]               wr_addr,
  output logic [7:0]                wr_data,
  output logic                      disp_bank,
  output logic [NREQ-1:0]           done_mask,
  output logic                      err_tile,
  output logic                      err_oob
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t         state, state_nxt;
  logic [NREQ-1:0]      arb_req, grant, done_nxt;
  logic [IW-1:0]        gidx;
  logic                 accept, oob;
  logic [TILE_BITS-1:0] sel_tile;
  logic [OFFS_BITS-1:0] sel_offs;
  logic [7:0]           sel_data;
  tile_info_t           ti;
  logic [13:0]          sum;
  logic [15:0]          addr_d;

  // Finished producers and every non-FILL state are masked out of arbitration.
  assign arb_req   = req_valid & ~done_mask & {NREQ{(state == FILL) && !rst}};
  assign req_ready = grant;
  assign accept    = |grant;

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .grant     (grant),
    .grant_idx (gidx)
  );

  always_comb begin
    sel_tile = req_tile[gidx*TILE_BITS +: TILE_BITS];
    sel_offs = req_offs[gidx*OFFS_BITS +: OFFS_BITS];
    sel_data = req_data[gidx*8 +: 8];
    ti       = tile_base(8'(sel_tile));
    oob      = 32'(sel_offs) >= 32'(ti.size);
    sum      = ti.base + 14'(sel_offs);
    addr_d   = '0;
    addr_d[13:0]     = sum;
    addr_d[BANK_BIT] = ~disp_bank;
    done_nxt = done_mask | (grant & req_last);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (&done_nxt) state_nxt = ARMED;
      ARMED:   if (sof)       state_nxt = SWAP;
      SWAP:                   state_nxt = FILL;
      default:                state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_tile  <= 1'b0;
      err_oob   <= 1'b0;
      disp_bank <= 1'b0;
      done_mask <= '0;
    end else begin
      wr_en <= accept && ti.valid && !oob;
      if (accept) begin
        wr_addr <= addr_d;
        wr_data <= sel_data;
      end
      if (accept && !ti.valid)       err_tile <= 1'b1;
      if (accept && ti.valid && oob) err_oob  <= 1'b1;
      if (state == SWAP) begin
        disp_bank <= ~disp_bank;
        done_mask <= '0;
      end else begin
        done_mask <= done_nxt;
      end
    end
  end

endmodule

// File: tb/tb_display_bram_scheduler.sv
// Directed bench for display_bram_scheduler: arbitration, addressing, errors,
// bank swap timing and mid-frame reset, with hand-computed expectations.
module tb_display_bram_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_last, done_mask;
  logic [19:0] req_tile;
  logic [39:0] req_offs;
  logic [31:0] req_data;
  logic        sof, wr_en, disp_bank, err_tile, err_oob;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;

  display_bram_scheduler #(.NREQ(4), .TILE_BITS(5), .OFFS_BITS(10), .BANK_BIT(14)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tile(req_tile), .req_offs(req_offs), .req_data(req_data),
    .req_last(req_last), .sof(sof), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .disp_bank(disp_bank), .done_mask(done_mask),
    .err_tile(err_tile), .err_oob(err_oob)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    req_valid = '0; req_last = '0; req_tile = '0; req_offs = '0; req_data = '0;
  endtask

  task automatic set_req(input int i, input logic [4:0] t, input logic [9:0] o,
                         input logic [7:0] d, input logic l);
    req_valid[i]      = 1'b1;
    req_last[i]       = l;
    req_tile[i*5+:5]  = t;
    req_offs[i*10+:10] = o;
    req_data[i*8+:8]  = d;
  endtask

  initial begin
    int g;
    rst = 1'b1; sof = 1'b0;
    clr_req();
    tick(); tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_bank", 32'(disp_bank), 0);
    chk("rst_done", 32'(done_mask), 0);
    chk("rst_errs", 32'({err_tile, err_oob}), 0);
    chk("rst_ready", 32'(req_ready), 0);
    rst = 1'b0;

    // single write: tile 1 offs 5 -> 0x4325 in the hidden bank
    set_req(0, 5'd1, 10'd5, 8'hAB, 1'b0);
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    chk("single_wr_en", 32'(wr_en), 1);
    chk("single_addr", 32'(wr_addr), 32'h4325);
    chk("single_data", 32'(wr_data), 32'hAB);
    clr_req();

    // rotation: pointer sits at 1 after the previous grant
    for (int i = 0; i < 4; i++) set_req(i, 5'd0, 10'(i), 8'(8'h10 + i), 1'b0);
    for (int k = 0; k < 6; k++) begin
      g = (1 + k) % 4;
      #1 chk("rot_ready", 32'(req_ready), 32'(1 << g));
      tick();
      chk("rot_wr_en", 32'(wr_en), 1);
      chk("rot_data", 32'(wr_data), 32'(8'h10 + g));
      chk("rot_addr", 32'(wr_addr), 32'(16'h4000 + g));
    end
    // pointer now 3; requester 3 drops out and is skipped without a bubble
    req_valid[3] = 1'b0;
    #1 chk("skip_ready0", 32'(req_ready), 32'h1);
    tick();
    chk("skip_wr_en0", 32'(wr_en), 1);
    chk("skip_data0", 32'(wr_data), 32'h10);
    #1 chk("skip_ready1", 32'(req_ready), 32'h2);
    tick();
    chk("skip_wr_en1", 32'(wr_en), 1);
    chk("skip_data1", 32'(wr_data), 32'h11);
    clr_req();

    // boundary offsets and bad tile, all through requester 2
    set_req(2, 5'd20, 10'd63, 8'h55, 1'b0);
    tick();
    chk("t20_63_wr_en", 32'(wr_en), 1);
    chk("t20_63_addr", 32'(wr_addr), 32'h681F);
    chk("t20_63_errs", 32'({err_tile, err_oob}), 0);
    set_req(2, 5'd20, 10'd64, 8'h56, 1'b0);
    tick();
    chk("t20_64_wr_en", 32'(wr_en), 0);
    chk("t20_64_oob", 32'(err_oob), 1);
    chk("t20_64_tile", 32'(err_tile), 0);
    set_req(2, 5'd22, 10'd0, 8'h57, 1'b0);
    tick();
    chk("t22_wr_en", 32'(wr_en), 0);
    chk("t22_err_tile", 32'(err_tile), 1);
    clr_req();
    tick(); tick();
    chk("errs_sticky", 32'({err_tile, err_oob}), 32'h3);

    // all four finish; pointer is 3 so order is 3,0,1,2
    for (int i = 0; i < 4; i++) set_req(i, 5'd0, 10'd0, 8'h00, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("done_count", 32'($countones(done_mask)), 32'(k + 1));
    end
    chk("last_fill_addr", 32'(wr_addr), 32'h4000);
    chk("last_fill_wr_en", 32'(wr_en), 1);
    #1 chk("armed_ready", 32'(req_ready), 0);
    repeat (10) tick();
    chk("armed_ready_hold", 32'(req_ready), 0);
    chk("armed_bank", 32'(disp_bank), 0);
    chk("armed_wr_en", 32'(wr_en), 0);
    clr_req();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    chk("swap_bank_early", 32'(disp_bank), 0);
    chk("swap_done_hold", 32'(done_mask), 32'hF);
    tick();
    chk("swap_bank", 32'(disp_bank), 1);
    chk("swap_done_clr", 32'(done_mask), 0);
    set_req(0, 5'd0, 10'd0, 8'h77, 1'b0);
    tick();
    chk("bank1_wr_en", 32'(wr_en), 1);
    chk("bank1_addr", 32'(wr_addr), 32'h0000);
    chk("bank1_data", 32'(wr_data), 32'h77);
    clr_req();

    // final last coincides with sof: no swap until the next sof
    for (int i = 0; i < 3; i++) begin
      set_req(i, 5'd0, 10'd1, 8'h01, 1'b1);
      tick();
      clr_req();
    end
    chk("pre_sof_done", 32'(done_mask), 32'h7);
    set_req(3, 5'd0, 10'd1, 8'h01, 1'b1);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    clr_req();
    tick(); tick();
    chk("coinc_no_swap", 32'(disp_bank), 1);
    chk("coinc_done", 32'(done_mask), 32'hF);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
    chk("coinc_swap", 32'(disp_bank), 0);
    chk("coinc_done_clr", 32'(done_mask), 0);

    // reset mid-frame with done_mask 0101 and a write in flight
    set_req(0, 5'd0, 10'd2, 8'h02, 1'b1);
    tick(); clr_req();
    set_req(2, 5'd0, 10'd2, 8'h02, 1'b1);
    tick(); clr_req();
    set_req(1, 5'd0, 10'd1, 8'h11, 1'b0);
    set_req(3, 5'd0, 10'd3, 8'h13, 1'b0);
    tick();
    req_valid[3] = 1'b0;
    tick();
    chk("mid_done", 32'(done_mask), 32'h5);
    chk("mid_wr_en", 32'(wr_en), 1);
    chk("mid_data", 32'(wr_data), 32'h11);
    rst = 1'b1;
    tick();
    chk("mrst_wr_en", 32'(wr_en), 0);
    chk("mrst_addr", 32'(wr_addr), 0);
    chk("mrst_data", 32'(wr_data), 0);
    chk("mrst_done", 32'(done_mask), 0);
    chk("mrst_errs", 32'({err_tile, err_oob}), 0);
    chk("mrst_bank", 32'(disp_bank), 0);
    chk("mrst_ready", 32'(req_ready), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 5'd0, 10'(i), 8'(8'h20 + i), 1'b0);
    #1 chk("restart_ready", 32'(req_ready), 32'h1);
    tick();
    chk("restart_data", 32'(wr_data), 32'h20);
    chk("restart_addr", 32'(wr_addr), 32'h4000);
    clr_req();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
